agc_timepulse_gen: RTL and testbench
====================================

Name: agc_timepulse_gen

Overview:
Timing generator that divides the simulation clock into the AGC memory-cycle timing frame.
- Twelve one-hot time pulses T01..T12, each split into four phases P1..P4.
- Sits directly upstream of the U74HC04/NOR gate chips in the timer sheet; its T/P outputs drive inverter inputs.
- Implements halt-at-end-of-cycle (STOP) and forced restart (GOJAM) behaviour.

Parameters:
DIV, 4, clk cycles per phase; legal range 2..255.
NT, 12, time pulses per memory cycle; fixed at 12, exposed for the bench only.

Ports:
clk  input  1  simulation clock; every register updates on its rising edge.
rst  input  1  synchronous, active-high reset.
vcc  input  1  power pin; no logic effect.
gnd  input  1  power pin; no logic effect.
stop  input  1  halt request; sampled at the end of T12 P4.
restart  input  1  GOJAM; forces the frame to T01 P1.
t  output  12  one-hot time pulse; bit 0 is T01.
p  output  4  one-hot phase within the current T; bit 0 is P1.
tick  output  1  one-cycle pulse on the first clk cycle of every new T.
mct  output  1  one-cycle pulse on the first clk cycle of every new memory cycle (T01 P1 entry).
stopped  output  1  high while in IDLE or HALT.

Behaviour:
- Prescaler
  - Counter cnt runs 0..DIV-1.
  - wrap = (cnt == DIV-1).
  - Width is clog2(DIV), minimum 1 bit.
- States
  - IDLE: after reset.
  - RUN: frame advancing.
  - HALT: stopped after a completed cycle.
- Reset
  - Takes effect on the rst=1 edge, in IDLE.
  - cnt=0, t=0, p=0, tick=0, mct=0, stopped=1.
- IDLE→RUN
  - Occurs on the first wrap after rst falls.
  - Sets t=T01, p=P1, tick=1, mct=1, stopped=0.
  - T01 is therefore first visible DIV cycles after the first clk edge with rst=0.
- RUN advance, on each wrap:
  - P advances P1→P2→P3→P4.
  - From P4, p→P1 and t rotates left by one, asserting tick.
  - From T12 P4, t→T01 and p→P1, asserting tick and mct, unless a halt occurs (next item).
- RUN→HALT
  - Condition: stop=1 on the wrap cycle that ends T12 P4.
  - Result: t=0, p=0, stopped=1; no tick, no mct.
  - stop at any other time has no effect.
- HALT→RUN
  - Condition: first wrap with stop=0.
  - Entry is identical to IDLE→RUN.
  - cnt keeps running in HALT.
- restart, from any state:
  - Next edge gives cnt=0, t=T01, p=P1, tick=1, mct=1, stopped=0.
  - Overrides stop and any pending wrap.
- Priority: rst > restart > wrap/stop.
- Pulse widths: tick and mct are high for exactly one clk cycle; otherwise 0.
- Invariants
  - In RUN, t and p are each exactly one-hot.
  - In IDLE/HALT, both are all-zero.
- Period: a full memory cycle lasts 4*NT*DIV clk cycles (192 at DIV=4).
- Registering: all outputs are registered, with no combinational path from stop or restart to any output.

Decomposition:
- Shared package agc_timing_pkg holds:
  - state encoding (IDLE/RUN/HALT);
  - NT=12 and NPH=4;
  - one-hot constants T01, T12, P1, P4.
- One sub-module, agc_prescaler.
  - Parameterised by DIV; inputs clk, rst, clr; output wrap.
  - clr is driven by restart.
- Rotation and state machine live in the top module.

Test Plan:
- Reset release (DIV=4): rst high 3 cycles, then low → t=0 and stopped=1 for cycles 1-3; t=12'h001, p=4'h1, mct=1 at cycle 4.
- Free run: after first T01, sample 192 cycles.
  - t steps 001→002→…→800→001.
  - p changes every 4 cycles.
  - tick seen 12 times; mct seen once per 192 cycles.
  - One-hot invariant holds every cycle.
- Stop: assert stop during T07 and hold → runs through T12 P4, then t=0, p=0, stopped=1, no mct.
  - Drop stop → T01 P1 with mct=1 on the next wrap.
- Restart mid-cycle: pulse restart for 1 cycle at T05 P3, cnt=2 → next edge t=12'h001, p=4'h1, tick=1, mct=1.
  - Next phase change comes exactly 4 cycles later.
- Simultaneous events:
  - restart with stop=1 at T12 P4 wrap → RUN at T01 P1, stopped=0.
  - rst with restart → IDLE, all outputs 0.
- DIV=2 sweep: memory-cycle period is 96 cycles; tick every 8 cycles.

Source files
------------

// File: rtl/agc_timing_pkg.sv
// Shared timing constants and FSM encoding for the AGC time-pulse generator.
package agc_timing_pkg;

  localparam int unsigned NT  = 12;
  localparam int unsigned NPH = 4;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StHalt
  } state_e;

  localparam logic [NT-1:0]  T01 = NT'(1);
  localparam logic [NT-1:0]  T12 = {1'b1, {(NT-1){1'b0}}};
  localparam logic [NPH-1:0] P1  = NPH'(1);
  localparam logic [NPH-1:0] P4  = {1'b1, {(NPH-1){1'b0}}};

endpackage

// File: rtl/agc_timepulse_gen_if.sv
// Control inputs and registered T/P timing outputs of the time-pulse generator.
interface agc_timepulse_gen_if;
  import agc_timing_pkg::*;

  logic           stop;
  logic           restart;
  logic [NT-1:0]  t;
  logic [NPH-1:0] p;
  logic           tick;
  logic           mct;
  logic           stopped;

  modport master (
    output stop,
    output restart,
    input  t,
    input  p,
    input  tick,
    input  mct,
    input  stopped
  );

  modport slave (
    input  stop,
    input  restart,
    output t,
    output p,
    output tick,
    output mct,
    output stopped
  );

endinterface

// File: rtl/agc_prescaler.sv
// Free-running divide-by-DIV counter; wrap marks the last clk cycle of each phase.
module agc_prescaler #(
  parameter int unsigned DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic wrap
);

  localparam int unsigned CntW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DIV - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign wrap = (cnt_q == CntMax);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr || wrap) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/agc_timepulse_gen.sv
// AGC memory-cycle timing frame: twelve one-hot T pulses of four phases each,
// with halt-at-end-of-cycle (stop) and forced restart (GOJAM).
module agc_timepulse_gen
  import agc_timing_pkg::*;
#(
  parameter int unsigned DIV = 4,
  parameter int unsigned NT  = 12
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               vcc,
  input  logic               gnd,
  agc_timepulse_gen_if.slave bus
);

  logic           wrap;
  state_e         state_q;
  logic [NT-1:0]  t_q;
  logic [NPH-1:0] p_q;
  logic           tick_q;
  logic           mct_q;
  logic           stopped_q;

  // Power pins exist only to mirror the schematic.
  logic unused_pwr;
  assign unused_pwr = vcc ^ gnd;

  agc_prescaler #(
    .DIV (DIV)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .clr  (bus.restart),
    .wrap (wrap)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      t_q       <= '0;
      p_q       <= '0;
      tick_q    <= 1'b0;
      mct_q     <= 1'b0;
      stopped_q <= 1'b1;
    end else if (bus.restart) begin
      state_q   <= StRun;
      t_q       <= T01;
      p_q       <= P1;
      tick_q    <= 1'b1;
      mct_q     <= 1'b1;
      stopped_q <= 1'b0;
    end else begin
      tick_q <= 1'b0;
      mct_q  <= 1'b0;
      if (wrap) begin
        unique case (state_q)
          StIdle, StHalt: begin
            // Idle starts on any wrap; a halted frame waits for stop to drop.
            if (state_q == StIdle || !bus.stop) begin
              state_q   <= StRun;
              t_q       <= T01;
              p_q       <= P1;
              tick_q    <= 1'b1;
              mct_q     <= 1'b1;
              stopped_q <= 1'b0;
            end
          end
          StRun: begin
            if (p_q != P4) begin
              p_q <= {p_q[NPH-2:0], 1'b0};
            end else if (t_q == T12 && bus.stop) begin
              state_q   <= StHalt;
              t_q       <= '0;
              p_q       <= '0;
              stopped_q <= 1'b1;
            end else begin
              t_q    <= {t_q[NT-2:0], t_q[NT-1]};
              p_q    <= P1;
              tick_q <= 1'b1;
              mct_q  <= (t_q == T12);
            end
          end
          default: begin
            state_q   <= StIdle;
            t_q       <= '0;
            p_q       <= '0;
            stopped_q <= 1'b1;
          end
        endcase
      end
    end
  end

  assign bus.t       = t_q;
  assign bus.p       = p_q;
  assign bus.tick    = tick_q;
  assign bus.mct     = mct_q;
  assign bus.stopped = stopped_q;

endmodule

// File: tb/tb_agc_timepulse_gen.sv
// Bench for agc_timepulse_gen at DIV=4 and DIV=2: time-based reference model
// checked every cycle, plus directed scenarios with literal expectations.
module tb_agc_timepulse_gen;
  import agc_timing_pkg::*;

  localparam int NDUT = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic stop = 1'b0;
  logic restart = 1'b0;
  logic vcc = 1'b1;
  logic gnd = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  agc_timepulse_gen_if bus4();
  agc_timepulse_gen_if bus2();

  assign bus4.stop    = stop;
  assign bus4.restart = restart;
  assign bus2.stop    = stop;
  assign bus2.restart = restart;

  agc_timepulse_gen #(.DIV(4), .NT(12)) u_dut4 (
    .clk (clk),
    .rst (rst),
    .vcc (vcc),
    .gnd (gnd),
    .bus (bus4)
  );

  agc_timepulse_gen #(.DIV(2), .NT(12)) u_dut2 (
    .clk (clk),
    .rst (rst),
    .vcc (vcc),
    .gnd (gnd),
    .bus (bus2)
  );

  logic [11:0] d_t       [NDUT];
  logic [3:0]  d_p       [NDUT];
  logic        d_tick    [NDUT];
  logic        d_mct     [NDUT];
  logic        d_stopped [NDUT];

  assign d_t[0] = bus4.t;       assign d_t[1] = bus2.t;
  assign d_p[0] = bus4.p;       assign d_p[1] = bus2.p;
  assign d_tick[0] = bus4.tick; assign d_tick[1] = bus2.tick;
  assign d_mct[0] = bus4.mct;   assign d_mct[1] = bus2.mct;
  assign d_stopped[0] = bus4.stopped;
  assign d_stopped[1] = bus2.stopped;

  initial forever #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  function automatic int div_of(input int i);
    return (i == 0) ? 4 : 2;
  endfunction

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s dut%0d @cyc %0d: got 0x%0h expected 0x%0h", name, idx, cyc, act, exp);
    end
  endtask

  // Reference model: the frame is a position (clk cycles since the last T01 P1 entry)
  // and the outputs are derived from it by division.
  int  m_sub  [NDUT];
  int  m_pos  [NDUT];
  bit  m_run  [NDUT];
  bit  m_halt [NDUT];
  bit  m_tick [NDUT];
  bit  m_mct  [NDUT];
  bit  m_valid = 1'b0;

  initial forever begin
    @(posedge clk);
    for (int i = 0; i < NDUT; i++) begin
      int d, frame;
      bit wrap;
      d = div_of(i);
      frame = 4 * 12 * d;
      m_tick[i] = 1'b0;
      m_mct[i]  = 1'b0;
      if (rst) begin
        m_sub[i] = 0; m_run[i] = 1'b0; m_halt[i] = 1'b0; m_pos[i] = 0;
      end else if (restart) begin
        m_sub[i] = 0; m_run[i] = 1'b1; m_halt[i] = 1'b0; m_pos[i] = 0;
        m_tick[i] = 1'b1; m_mct[i] = 1'b1;
      end else begin
        wrap = (m_sub[i] == d - 1);
        m_sub[i] = (m_sub[i] + 1) % d;
        if (m_run[i]) begin
          if (wrap && m_pos[i] == frame - 1 && stop) begin
            m_run[i] = 1'b0; m_halt[i] = 1'b1;
          end else begin
            m_pos[i] = (m_pos[i] + 1) % frame;
            m_tick[i] = (m_pos[i] % (4 * d) == 0);
            m_mct[i]  = (m_pos[i] == 0);
          end
        end else if (wrap && !(m_halt[i] && stop)) begin
          m_run[i] = 1'b1; m_halt[i] = 1'b0; m_pos[i] = 0;
          m_tick[i] = 1'b1; m_mct[i] = 1'b1;
        end
      end
    end
    m_valid = 1'b1;
  end

  initial forever begin
    @(negedge clk);
    if (m_valid) begin
      for (int i = 0; i < NDUT; i++) begin
        logic [11:0] et;
        logic [3:0]  ep;
        int d;
        d  = div_of(i);
        et = m_run[i] ? (12'h001 << (m_pos[i] / (4 * d))) : 12'h000;
        ep = m_run[i] ? (4'h1 << ((m_pos[i] / d) % 4)) : 4'h0;
        check("t", i, 32'(d_t[i]), 32'(et));
        check("p", i, 32'(d_p[i]), 32'(ep));
        check("tick", i, 32'(d_tick[i]), 32'(m_tick[i]));
        check("mct", i, 32'(d_mct[i]), 32'(m_mct[i]));
        check("stopped", i, 32'(d_stopped[i]), 32'(!m_run[i]));
      end
    end
  end

  // Waits (sampling at posedge+3) until DIV=4 instance shows the given T/P.
  task automatic wait_tp4(input logic [11:0] tt, input logic [3:0] pp, input int budget);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < budget && !ok; k++) begin
      @(posedge clk); #3;
      ok = (bus4.t == tt) && (bus4.p == pp);
    end
    check("wait_tp", 0, 32'(ok), 32'd1);
  endtask

  // sel: 0 bus2.mct, 1 bus2.tick, 2 bus4.stopped, 3 bus4.t nonzero.
  task automatic wait_sig(input int sel, input int budget, output int at);
    bit ok;
    ok = 1'b0;
    at = -1;
    for (int k = 0; k < budget && !ok; k++) begin
      @(posedge clk); #3;
      unique case (sel)
        0: ok = bus2.mct;
        1: ok = bus2.tick;
        2: ok = bus4.stopped;
        default: ok = (bus4.t != 12'h000);
      endcase
    end
    if (ok) at = cyc;
    check("wait_sig", sel, 32'(ok), 32'd1);
  endtask

  initial begin
    int n_tick4, n_mct4, n_tick2, n_mct2, c0, c1, c2, nchg;

    // Reset release: T01 appears DIV cycles after the first edge with rst low.
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #3;
      if (k < 4) begin
        check("rel_t", 0, 32'(bus4.t), 32'h000);
        check("rel_p", 0, 32'(bus4.p), 32'h0);
        check("rel_stopped", 0, 32'(bus4.stopped), 32'd1);
      end else begin
        check("rel_t", 0, 32'(bus4.t), 32'h001);
        check("rel_p", 0, 32'(bus4.p), 32'h1);
        check("rel_mct", 0, 32'(bus4.mct), 32'd1);
      end
    end

    // Free run over one DIV=4 memory cycle.
    n_tick4 = 0; n_mct4 = 0; n_tick2 = 0; n_mct2 = 0;
    repeat (192) begin
      @(posedge clk); #3;
      n_tick4 += int'(bus4.tick); n_mct4 += int'(bus4.mct);
      n_tick2 += int'(bus2.tick); n_mct2 += int'(bus2.mct);
    end
    check("run_ticks", 0, 32'(n_tick4), 32'd12);
    check("run_mcts", 0, 32'(n_mct4), 32'd1);
    check("run_ticks", 1, 32'(n_tick2), 32'd24);
    check("run_mcts", 1, 32'(n_mct2), 32'd2);

    // Stop raised in T07 halts only after T12 P4.
    wait_tp4(12'h040, 4'h1, 300);
    stop = 1'b1;
    wait_sig(2, 300, c0);
    check("halt_t", 0, 32'(bus4.t), 32'h000);
    check("halt_p", 0, 32'(bus4.p), 32'h0);
    check("halt_mct", 0, 32'(bus4.mct), 32'd0);
    repeat (10) @(posedge clk);
    #3 check("halt_hold", 0, 32'(bus4.stopped), 32'd1);
    stop = 1'b0;
    wait_sig(3, 20, c1);
    check("resume_t", 0, 32'(bus4.t), 32'h001);
    check("resume_p", 0, 32'(bus4.p), 32'h1);
    check("resume_mct", 0, 32'(bus4.mct), 32'd1);

    // Restart at T05 P3 with cnt=2.
    wait_tp4(12'h010, 4'h4, 300);
    repeat (2) @(posedge clk);
    #2 restart = 1'b1;
    @(posedge clk);
    #2 restart = 1'b0;
    #1;
    check("rs_t", 0, 32'(bus4.t), 32'h001);
    check("rs_p", 0, 32'(bus4.p), 32'h1);
    check("rs_tick", 0, 32'(bus4.tick), 32'd1);
    check("rs_mct", 0, 32'(bus4.mct), 32'd1);
    nchg = 0;
    for (int k = 1; k <= 8 && nchg == 0; k++) begin
      @(posedge clk); #3;
      if (bus4.p != 4'h1) nchg = k;
    end
    check("rs_phase_len", 0, 32'(nchg), 32'd4);

    // restart wins over stop on the T12 P4 wrap.
    wait_tp4(12'h800, 4'h8, 300);
    stop = 1'b1;
    @(posedge clk); @(posedge clk); @(posedge clk);
    #2 restart = 1'b1;
    @(posedge clk);
    #2 restart = 1'b0; stop = 1'b0;
    #1;
    check("rs_stop_t", 0, 32'(bus4.t), 32'h001);
    check("rs_stop_p", 0, 32'(bus4.p), 32'h1);
    check("rs_stop_stopped", 0, 32'(bus4.stopped), 32'd0);

    // rst wins over restart.
    @(posedge clk);
    #2 rst = 1'b1; restart = 1'b1;
    @(posedge clk);
    #2 rst = 1'b0; restart = 1'b0;
    #1;
    check("rst_rs_t", 0, 32'(bus4.t), 32'h000);
    check("rst_rs_p", 0, 32'(bus4.p), 32'h0);
    check("rst_rs_tick", 0, 32'(bus4.tick), 32'd0);
    check("rst_rs_mct", 0, 32'(bus4.mct), 32'd0);
    check("rst_rs_stopped", 0, 32'(bus4.stopped), 32'd1);

    // DIV=2 periods.
    wait_sig(0, 20, c0);
    wait_sig(1, 20, c1);
    check("div2_tick_period", 1, 32'(c1 - c0), 32'd8);
    wait_sig(0, 200, c2);
    check("div2_mct_period", 1, 32'(c2 - c0), 32'd96);

    // Randomised control traffic against the model.
    repeat (4000) begin
      @(posedge clk); #2;
      rst     = ($urandom_range(0, 399) == 0);
      restart = ($urandom_range(0, 79) == 0);
      if ($urandom_range(0, 47) == 0) stop = ~stop;
    end
    @(posedge clk); #2;
    rst = 1'b0; restart = 1'b0; stop = 1'b0;
    repeat (4) @(posedge clk);
    #3;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got time %0t expected < 2000000", $time);
    $fatal(1, "watchdog");
  end

endmodule
